// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM port arbiter.
//   ARB_RR / ARB_FIXED : arbitration mode selectors (ArbMode parameter)
//   AW_DEFAULT / DW_DEFAULT : default SRAM address / word widths
//   TAG_A / TAG_B      : owner tag carried alongside an in-flight read; also
//                        the bit index of each port in the 2-bit req/gnt vectors
package sram_arb_pkg;

    localparam int ARB_RR     = 0;
    localparam int ARB_FIXED  = 1;

    localparam int AW_DEFAULT = 12;
    localparam int DW_DEFAULT = 144;

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input arbiter with a last-grant pointer.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   req_i   : requests, bit TAG_A = port A, bit TAG_B = port B
//   mode_i  : 0 = round-robin, 1 = fixed priority (port A wins)
//   gnt_o   : combinational grant, at most one bit set, never without req
module rr_arbiter2
    import sram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       mode_i,
    output logic [1:0] gnt_o
);

    // 1 = port B received the most recent accepted grant.
    logic last_b_q;
    logic last_b_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Tie: fixed mode always favours A; round-robin favours the
            // port that did not win last time.
            2'b11:   gnt_o = (mode_i || last_b_q) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // A request is held until granted, so any grant is an accepted grant.
    always_comb begin
        last_b_d = last_b_q;
        if (|gnt_o) begin
            last_b_d = gnt_o[TAG_B];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter and sequencer for a single-port synchronous SRAM with
// active-low controls and a one-cycle registered read.
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   req_x_i / we_x_i             : request (held until granted) and write flag
//   addr_x_i / wdata_x_i         : access address and write data
//   gnt_x_o                      : combinational grant
//   rvalid_x_o / rdata_x_o       : one-cycle read-data strobe and data
//   mem_a_o / mem_d_o            : registered SRAM address / write data
//   mem_cen_o/mem_wen_o/mem_oen_o: registered SRAM controls, active low
//   mem_q_i                      : SRAM read data
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AddressWidth = AW_DEFAULT,
    parameter int DataWidth    = DW_DEFAULT,
    parameter int ArbMode      = ARB_RR
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_a_i,
    input  logic                    we_a_i,
    input  logic [AddressWidth-1:0] addr_a_i,
    input  logic [DataWidth-1:0]    wdata_a_i,
    input  logic                    req_b_i,
    input  logic                    we_b_i,
    input  logic [AddressWidth-1:0] addr_b_i,
    input  logic [DataWidth-1:0]    wdata_b_i,
    output logic                    gnt_a_o,
    output logic                    gnt_b_o,
    output logic                    rvalid_a_o,
    output logic [DataWidth-1:0]    rdata_a_o,
    output logic                    rvalid_b_o,
    output logic [DataWidth-1:0]    rdata_b_o,
    output logic [AddressWidth-1:0] mem_a_o,
    output logic [DataWidth-1:0]    mem_d_o,
    output logic                    mem_cen_o,
    output logic                    mem_wen_o,
    output logic                    mem_oen_o,
    input  logic [DataWidth-1:0]    mem_q_i
);

    logic [1:0] gnt;

    rr_arbiter2 u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  ({req_b_i, req_a_i}),
        .mode_i (ArbMode == ARB_FIXED),
        .gnt_o  (gnt)
    );

    assign gnt_a_o = gnt[TAG_A];
    assign gnt_b_o = gnt[TAG_B];

    // Command of the granted port.
    logic                    issue;
    logic                    cmd_tag;
    logic                    cmd_we;
    logic [AddressWidth-1:0] cmd_addr;
    logic [DataWidth-1:0]    cmd_wdata;

    assign issue     = |gnt;
    assign cmd_tag   = gnt[TAG_B] ? TAG_B : TAG_A;
    assign cmd_we    = gnt[TAG_B] ? we_b_i    : we_a_i;
    assign cmd_addr  = gnt[TAG_B] ? addr_b_i  : addr_a_i;
    assign cmd_wdata = gnt[TAG_B] ? wdata_b_i : wdata_a_i;

    // SRAM pin registers.
    logic                    mem_cen_q, mem_cen_d;
    logic                    mem_wen_q, mem_wen_d;
    logic                    mem_oen_q;
    logic [AddressWidth-1:0] mem_a_q, mem_a_d;
    logic [DataWidth-1:0]    mem_d_q, mem_d_d;

    // Read owner-tag pipeline: stage 1 marks a read presented to the SRAM,
    // stage 2 lines up with the SRAM's registered output.
    logic rd_vld_q, rd_vld_d;
    logic rd_tag_q, rd_tag_d;
    logic rvalid_a_q, rvalid_a_d;
    logic rvalid_b_q, rvalid_b_d;

    always_comb begin
        mem_cen_d  = ~issue;
        mem_wen_d  = ~(issue & cmd_we);
        mem_a_d    = issue ? cmd_addr : mem_a_q;
        // Write data is only meaningful on writes; hold it otherwise so the
        // data bus does not toggle on reads.
        mem_d_d    = (issue & cmd_we) ? cmd_wdata : mem_d_q;
        rd_vld_d   = issue & ~cmd_we;
        rd_tag_d   = cmd_tag;
        rvalid_a_d = rd_vld_q & (rd_tag_q == TAG_A);
        rvalid_b_d = rd_vld_q & (rd_tag_q == TAG_B);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_cen_q  <= 1'b1;
            mem_wen_q  <= 1'b1;
            mem_oen_q  <= 1'b1;
            mem_a_q    <= '0;
            mem_d_q    <= '0;
            rd_vld_q   <= 1'b0;
            rd_tag_q   <= TAG_A;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            mem_cen_q  <= mem_cen_d;
            mem_wen_q  <= mem_wen_d;
            // Output enable is released once after reset and then stays on.
            mem_oen_q  <= 1'b0;
            mem_a_q    <= mem_a_d;
            mem_d_q    <= mem_d_d;
            rd_vld_q   <= rd_vld_d;
            rd_tag_q   <= rd_tag_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    assign mem_cen_o  = mem_cen_q;
    assign mem_wen_o  = mem_wen_q;
    assign mem_oen_o  = mem_oen_q;
    assign mem_a_o    = mem_a_q;
    assign mem_d_o    = mem_d_q;
    assign rvalid_a_o = rvalid_a_q;
    assign rvalid_b_o = rvalid_b_q;
    assign rdata_a_o  = mem_q_i;
    assign rdata_b_o  = mem_q_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: a round-robin instance driven
// against a behavioural SRAM, plus a fixed-priority instance on the same
// request inputs.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 144;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;

    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b, mem_d, mem_q;
    logic [AW-1:0] mem_a;
    logic          mem_cen, mem_wen, mem_oen;

    logic          fx_gnt_a, fx_gnt_b, fx_rvalid_a, fx_rvalid_b;
    logic [DW-1:0] fx_rdata_a, fx_rdata_b, fx_mem_d;
    logic [AW-1:0] fx_mem_a;
    logic          fx_cen, fx_wen, fx_oen;

    always #5 clk = ~clk;

    sram_port_arbiter #(.AddressWidth(AW), .DataWidth(DW), .ArbMode(ARB_RR)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_a_i(req_a), .we_a_i(we_a), .addr_a_i(addr_a), .wdata_a_i(wdata_a),
        .req_b_i(req_b), .we_b_i(we_b), .addr_b_i(addr_b), .wdata_b_i(wdata_b),
        .gnt_a_o(gnt_a), .gnt_b_o(gnt_b),
        .rvalid_a_o(rvalid_a), .rdata_a_o(rdata_a),
        .rvalid_b_o(rvalid_b), .rdata_b_o(rdata_b),
        .mem_a_o(mem_a), .mem_d_o(mem_d), .mem_cen_o(mem_cen),
        .mem_wen_o(mem_wen), .mem_oen_o(mem_oen), .mem_q_i(mem_q)
    );

    sram_port_arbiter #(.AddressWidth(AW), .DataWidth(DW), .ArbMode(ARB_FIXED)) dut_fx (
        .clk_i(clk), .rst_i(rst),
        .req_a_i(req_a), .we_a_i(we_a), .addr_a_i(addr_a), .wdata_a_i(wdata_a),
        .req_b_i(req_b), .we_b_i(we_b), .addr_b_i(addr_b), .wdata_b_i(wdata_b),
        .gnt_a_o(fx_gnt_a), .gnt_b_o(fx_gnt_b),
        .rvalid_a_o(fx_rvalid_a), .rdata_a_o(fx_rdata_a),
        .rvalid_b_o(fx_rvalid_b), .rdata_b_o(fx_rdata_b),
        .mem_a_o(fx_mem_a), .mem_d_o(fx_mem_d), .mem_cen_o(fx_cen),
        .mem_wen_o(fx_wen), .mem_oen_o(fx_oen), .mem_q_i(mem_q)
    );

    // Behavioural single-port SRAM: samples on posedge, registered read.
    logic [DW-1:0] sram_mem [1<<AW];
    logic [DW-1:0] sram_q;
    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) sram_mem[mem_a] <= mem_d;
            else          sram_q <= sram_mem[mem_a];
        end
    end
    assign mem_q = mem_oen ? '0 : sram_q;

    // Reference model state.
    typedef struct {
        int            due;
        bit            port_b;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] ref_mem [1<<AW];
    rsp_t          rsp_q[$];
    bit            rr_last_b;
    logic [AW-1:0] exp_a, exp_fx_a;
    logic [DW-1:0] exp_d, exp_fx_d;
    bit [1:0]      fx_s1;
    int            cyc;
    int            checks = 0;
    int            failures = 0;

    // Grant snapshots of the last cycle() call and read-valid counter.
    bit snap_ga, snap_gb, snap_fa, snap_fb;
    int rva_seen;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    // One clock: drive inputs, check combinational grants against the
    // arbitration rules, advance the model, check registered outputs.
    task automatic cycle(input bit ra, input bit rb, input bit wa, input bit wb,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                         input logic [DW-1:0] da, input logic [DW-1:0] db);
        bit ga, gb, fa, fb, acc, w, facc, fw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit [1:0] fx_exp_rv;
        req_a = ra; req_b = rb; we_a = wa; we_b = wb;
        addr_a = aa; addr_b = ab; wdata_a = da; wdata_b = db;
        #1;
        // Round-robin: a lone request wins; on a tie the port not granted last.
        ga = ra && (!rb || rr_last_b);
        gb = rb && !ga;
        fa = ra;
        fb = rb && !ra;
        chk("gnt_a", gnt_a, ga);
        chk("gnt_b", gnt_b, gb);
        chk("fx_gnt_a", fx_gnt_a, fa);
        chk("fx_gnt_b", fx_gnt_b, fb);
        snap_ga = gnt_a; snap_gb = gnt_b; snap_fa = fx_gnt_a; snap_fb = fx_gnt_b;

        acc = ga || gb;
        w   = gb ? wb : wa;
        a   = gb ? ab : aa;
        d   = gb ? db : da;
        if (acc) begin
            rr_last_b = gb;
            exp_a = a;
            if (w) begin
                ref_mem[a] = d;
                exp_d = d;
            end else begin
                rsp_q.push_back('{due: cyc + 2, port_b: gb, data: ref_mem[a]});
            end
        end
        facc = fa || fb;
        fw   = fb ? wb : wa;
        if (facc) begin
            exp_fx_a = fb ? ab : aa;
            if (fw) exp_fx_d = fb ? db : da;
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("mem_cen", mem_cen, !acc);
        chk("mem_wen", mem_wen, !(acc && w));
        chk("mem_a", mem_a, exp_a);
        chk("mem_d", mem_d, exp_d);
        chk("mem_oen", mem_oen, 1'b0);
        chk("fx_cen", fx_cen, !facc);
        chk("fx_wen", fx_wen, !(facc && fw));
        chk("fx_mem_a", fx_mem_a, exp_fx_a);
        chk("fx_mem_d", fx_mem_d, exp_fx_d);
        chk("fx_oen", fx_oen, 1'b0);
        fx_exp_rv = fx_s1;
        fx_s1 = {fb && !fw, fa && !fw};
        chk("fx_rvalid_a", fx_rvalid_a, fx_exp_rv[0]);
        chk("fx_rvalid_b", fx_rvalid_b, fx_exp_rv[1]);
        chk("fx_rdata_b", fx_rdata_b, mem_q);
        check_rsp();
    endtask

    task automatic check_rsp();
        bit va, vb;
        logic [DW-1:0] dat;
        va = 1'b0; vb = 1'b0; dat = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            va  = !rsp_q[0].port_b;
            vb  = rsp_q[0].port_b;
            dat = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
        chk("rvalid_a", rvalid_a, va);
        chk("rvalid_b", rvalid_b, vb);
        chk("rvalid_both", rvalid_a && rvalid_b, 1'b0);
        if (va) chk("rdata_a", rdata_a, dat);
        if (vb) chk("rdata_b", rdata_b, dat);
        if (rvalid_a) rva_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, '0, '0, '0);
    endtask

    // Assert reset at the current negedge (may be mid-operation), check the
    // pins clear at once, hold, then release.
    task automatic do_reset();
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        #1;
        rsp_q.delete();
        rr_last_b = 1'b1;
        exp_a = '0; exp_d = '0; exp_fx_a = '0; exp_fx_d = '0; fx_s1 = 2'b00;
        chk("rst_mem_cen", mem_cen, 1'b1);
        chk("rst_mem_wen", mem_wen, 1'b1);
        chk("rst_mem_oen", mem_oen, 1'b1);
        chk("rst_mem_a", mem_a, '0);
        chk("rst_mem_d", mem_d, '0);
        chk("rst_rvalid_a", rvalid_a, 1'b0);
        chk("rst_rvalid_b", rvalid_b, 1'b0);
        chk("rst_gnt_a", gnt_a, 1'b0);
        chk("rst_gnt_b", gnt_b, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_hold_rvalid_a", rvalid_a, 1'b0);
            chk("rst_hold_rvalid_b", rvalid_b, 1'b0);
            chk("rst_hold_cen", mem_cen, 1'b1);
        end
        rst = 1'b0;
        #1;
        chk("oen_before_edge", mem_oen, 1'b1);
    endtask

    typedef struct {
        bit ra, rb, wa, wb;
        bit ga, gb, fa, fb;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input bit ra, input bit rb, input bit wa, input bit wb,
                                input bit ga, input bit gb, input bit fa, input bit fb);
        vec_t v;
        v.ra = ra; v.rb = rb; v.wa = wa; v.wb = wb;
        v.ga = ga; v.gb = gb; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    initial begin
        bit            pa, pb, pwa, pwb;
        logic [AW-1:0] paa, pab;
        logic [DW-1:0] pda, pdb;
        int            rvab;

        // Grant sequence after reset (round-robin expected, fixed expected).
        for (int i = 0; i < 6; i++)
            vecs[i] = mk(1, 1, 0, 0, (i % 2) == 0, (i % 2) == 1, 1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 0, 1, 0, 1, 0, 1, 0);
        vecs[8]  = mk(1, 1, 0, 0, 0, 1, 1, 0);
        vecs[9]  = mk(0, 1, 0, 1, 0, 1, 0, 1);
        vecs[10] = mk(1, 1, 0, 0, 1, 0, 1, 0);
        vecs[11] = mk(1, 1, 0, 0, 0, 1, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(1, 1, 0, 0, 1, 0, 1, 0);

        cyc = 0;
        rva_seen = 0;
        @(negedge clk);
        do_reset();

        // Idle after reset.
        idle(10);

        // Preload addresses 0..15 through port B.
        for (int i = 0; i < 16; i++)
            cycle(0, 1, 0, 1, '0, AW'(i), '0, rand_word());

        // A writes, B reads the same address on the next grant.
        cycle(1, 0, 1, 0, AW'('h010), '0, DW'('h5A5), '0);
        cycle(0, 1, 0, 0, '0, AW'('h010), '0, '0);
        idle(1);
        chk("wr_rd_rvalid_b", rvalid_b, 1'b1);
        chk("wr_rd_rdata_b", rdata_b, DW'('h5A5));
        chk("wr_rd_rvalid_a", rvalid_a, 1'b0);
        idle(2);

        // Table-driven grant sequence from a fresh reset.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].ra, vecs[i].rb, vecs[i].wa, vecs[i].wb,
                  AW'(i), AW'(i + 1), DW'(i * 7 + 1), DW'(i * 11 + 2));
            chk($sformatf("vec%0d_ga", i), snap_ga, vecs[i].ga);
            chk($sformatf("vec%0d_gb", i), snap_gb, vecs[i].gb);
            chk($sformatf("vec%0d_fa", i), snap_fa, vecs[i].fa);
            chk($sformatf("vec%0d_fb", i), snap_fb, vecs[i].fb);
        end
        idle(3);

        // Eight back-to-back reads on port A of addresses preloaded with i*3.
        for (int i = 0; i < 8; i++)
            cycle(1, 0, 1, 0, AW'(i), '0, DW'(i * 3), '0);
        rva_seen = 0;
        for (int i = 0; i < 8; i++)
            cycle(1, 0, 0, 0, AW'(i), '0, '0, '0);
        idle(2);
        chk("burst_rvalid_count", DW'(rva_seen), DW'(8));

        // Reset the cycle after a read accept: the read must never return.
        cycle(1, 0, 0, 0, AW'(5), '0, '0, '0);
        do_reset();
        cycle(1, 1, 0, 0, AW'(1), AW'(2), '0, '0);
        chk("post_rst_tie_gnt_a", snap_ga, 1'b1);
        idle(3);

        // Randomised traffic; a request stays up with its command until granted.
        pa = 0; pb = 0; pwa = 0; pwb = 0; paa = '0; pab = '0; pda = '0; pdb = '0;
        rvab = 0;
        for (int n = 0; n < 10000; n++) begin
            if (!pa && $urandom_range(0, 3) != 0) begin
                pa = 1; pwa = $urandom_range(0, 2) == 0;
                paa = AW'($urandom_range(0, 15)); pda = rand_word();
            end
            if (!pb && $urandom_range(0, 3) != 0) begin
                pb = 1; pwb = $urandom_range(0, 2) == 0;
                pab = AW'($urandom_range(0, 15)); pdb = rand_word();
            end
            cycle(pa, pb, pwa, pwb, paa, pab, pda, pdb);
            if (snap_ga) pa = 0;
            if (snap_gb) pb = 0;
            if (rvalid_a && rvalid_b) rvab++;
        end
        idle(3);
        chk("random_both_rvalid", DW'(rvab), '0);
        chk("random_queue_drained", DW'(rsp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
